lynx_ram_arbiter: RTL and testbench
===================================

LYNX_RAM_ARBITER -- requirements
Module: lynx_ram_arbiter

Interface
REQ-001 Parameters: DL_INDEX, 8'd1, ioctl_index value that targets RAM; DL_BASE, 16'h0000, RAM address of download byte 0.
REQ-002 clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 vid_req / vid_addr  in  1 / 16  video fetch request and address; vid_dout  out  8; vid_ack  out  1.
REQ-005 cpu_req / cpu_we / cpu_addr / cpu_din  in  1 / 1 / 16 / 8  CPU access; cpu_dout  out  8; cpu_ack  out  1.
REQ-006 ioctl_download / ioctl_wr  in  1 / 1; ioctl_addr  in  25; ioctl_dout  in  8; ioctl_index  in  8; ioctl_wait  out  1.
REQ-007 ram_addr  out  16; ram_we  out  1; ram_din  out  8; ram_dout  in  8 (synchronous RAM, 1-cycle read latency).
REQ-008 cpu_hold  out  1  CPU must be halted; dl_overrun  out  1  sticky lost-byte flag.

Function
REQ-009 Download active (dl_act) SHALL be ioctl_download AND ioctl_index==DL_INDEX; cpu_hold SHALL equal dl_act registered (1-cycle delay).
REQ-010 On ioctl_wr with dl_act and ioctl_addr[24:16]==0, the block SHALL latch byte and address (ioctl_addr[15:0]+DL_BASE, mod 2^16) into a one-entry buffer and set pending; writes with ioctl_addr[24:16]!=0 SHALL be discarded silently.
REQ-011 ioctl_wait SHALL be asserted in the cycle after a byte is latched and held until that byte is written to RAM.
REQ-012 ioctl_wr arriving while pending=1 SHALL drop the new byte, keep the buffered byte, and set dl_overrun until reset.
REQ-013 States: IDLE, ADDR, DATA. Each access takes exactly 2 cycles: ADDR drives ram_addr/ram_we/ram_din; DATA captures ram_dout and pulses the requester's ack for one cycle; then IDLE or directly ADDR of next grant.
REQ-014 Grant decision SHALL occur in IDLE or DATA (back-to-back allowed); priority video > download > CPU.
REQ-015 Fairness: after 2 consecutive video grants, a pending download or CPU request SHALL win the next grant.
REQ-016 CPU requests SHALL not be granted while cpu_hold=1; a CPU request granted before hold asserts SHALL complete normally.
REQ-017 ram_we SHALL be 1 only in ADDR of a download grant or a CPU grant with cpu_we=1; in all other cycles ram_we=0.
REQ-018 Requests SHALL be level: requester holds req/addr/data until ack; vid_req/cpu_req dropped before grant SHALL be ignored; after ack, req still high SHALL be treated as a new request.
REQ-019 cpu_dout/vid_dout SHALL update only on their own ack cycle and hold value otherwise; write acks leave cpu_dout unchanged.
REQ-020 Download end (ioctl_download falling) with pending=1 SHALL still drain the buffered byte; cpu_hold SHALL deassert only after pending clears.

Reset
REQ-021 In any cycle with reset=1: state IDLE, pending=0, ioctl_wait=0, vid_ack=0, cpu_ack=0, ram_we=0, cpu_hold=0, dl_overrun=0, cpu_dout=vid_dout=8'h00, ram_addr=16'h0000, fairness counter 0.
REQ-022 Reset mid-access SHALL abandon it with no ack and no RAM write in the following cycle.

Verification
REQ-023 cpu_req, cpu_we=0, addr 16'h1234, RAM holds 8'hA5 -> cpu_ack 2 cycles after request seen, cpu_dout=8'hA5.
REQ-024 vid_req and cpu_req asserted continuously -> grant order VID, VID, CPU, VID, VID, CPU; no ack pulse overlaps.
REQ-025 ioctl_download=1, index 8'd1, DL_BASE 16'h4000, ioctl_wr addr 25'h0010 data 8'h3C -> ioctl_wait next cycle, RAM[16'h4010]=8'h3C, ioctl_wait clears, cpu_hold=1 throughout.
REQ-026 Second ioctl_wr while ioctl_wait=1 -> byte dropped, dl_overrun=1, first byte still written.
REQ-027 ioctl_wr with ioctl_addr 25'h10000 -> no RAM write, ioctl_wait stays 0; ioctl_index 8'd2 -> no latch, cpu_hold=0.
REQ-028 reset pulsed during DATA of CPU write -> no cpu_ack, all outputs at REQ-021 values next cycle.

Source files
------------

// File: rtl/lynx_ram_arbiter.sv
// lynx_ram_arbiter
//   Shares one synchronous single-port RAM (1-cycle read latency) between
//   video fetch, CPU and a host download stream (ioctl).
//   Every access takes two cycles: ADDR presents address/write strobe,
//   DATA captures the read data and pulses the requester's ack.
//   The next grant is decided in IDLE or DATA, so accesses can run
//   back-to-back. Priority is video > download > CPU. After two consecutive
//   video grants, a waiting download/CPU request wins the next grant.
//
// Ports
//   clk_sys, reset               clock, synchronous active-high reset
//   vid_req/vid_addr             video request (level, held until ack)
//   vid_dout/vid_ack             video read data / one-cycle ack
//   cpu_req/we/addr/din          CPU request (level, held until ack)
//   cpu_dout/cpu_ack             CPU read data / one-cycle ack
//   ioctl_*                      host download port; ioctl_wait = buffer busy
//   ram_addr/we/din, ram_dout    RAM port
//   cpu_hold                     CPU must stay halted (download in progress)
//   dl_overrun                   sticky: a download byte was dropped
module lynx_ram_arbiter #(
  parameter logic [7:0]  DL_INDEX = 8'd1,
  parameter logic [15:0] DL_BASE  = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_dout,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        cpu_hold,
  output logic        dl_overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic [1:0] {G_NONE, G_VID, G_DL, G_CPU} gnt_t;

  state_t      state_q;
  gnt_t        gnt_q;
  gnt_t        gnt_d;
  logic [1:0]  vcnt_q;
  logic        pend_q;
  logic [15:0] buf_addr_q;
  logic [7:0]  buf_data_q;
  logic        ovr_q;
  logic        hold_q;
  logic [15:0] ram_addr_q;
  logic        ram_we_q;
  logic [7:0]  ram_din_q;
  logic        vid_ack_q;
  logic        cpu_ack_q;
  logic [7:0]  vid_dout_q;
  logic [7:0]  cpu_dout_q;
  logic        cpu_we_q;

  logic dl_act;
  logic dl_wr_ok;
  logic cpu_ok;
  logic decide;
  logic vid_blocked;

  assign dl_act      = ioctl_download && (ioctl_index == DL_INDEX);
  assign dl_wr_ok    = ioctl_wr && dl_act && (ioctl_addr[24:16] == '0);
  assign cpu_ok      = cpu_req && !hold_q;
  assign decide      = (state_q == S_IDLE) || (state_q == S_DATA);
  // Fairness: video yields once it has taken two grants in a row.
  assign vid_blocked = (vcnt_q == 2'd2) && (pend_q || cpu_ok);

  always_comb begin
    gnt_d = G_NONE;
    if (decide) begin
      if (vid_req && !vid_blocked) gnt_d = G_VID;
      else if (pend_q)             gnt_d = G_DL;
      else if (cpu_ok)             gnt_d = G_CPU;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= G_NONE;
      vcnt_q     <= '0;
      pend_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      ovr_q      <= 1'b0;
      hold_q     <= 1'b0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_dout_q <= '0;
      cpu_dout_q <= '0;
      cpu_we_q   <= 1'b0;
    end else begin
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      ram_we_q  <= 1'b0;
      // Hold stays up while a buffered byte is still waiting to drain.
      hold_q    <= dl_act || pend_q;

      if (dl_wr_ok) begin
        if (pend_q) begin
          ovr_q <= 1'b1;
        end else begin
          pend_q     <= 1'b1;
          buf_addr_q <= ioctl_addr[15:0] + DL_BASE;
          buf_data_q <= ioctl_dout;
        end
      end

      if (state_q == S_ADDR) begin
        state_q   <= S_DATA;
        vid_ack_q <= (gnt_q == G_VID);
        cpu_ack_q <= (gnt_q == G_CPU);
        // The byte is written at the end of ADDR; the buffer is free from DATA on.
        if (gnt_q == G_DL) pend_q <= 1'b0;
      end

      if (state_q == S_DATA) begin
        if (gnt_q == G_VID) vid_dout_q <= ram_dout;
        if ((gnt_q == G_CPU) && !cpu_we_q) cpu_dout_q <= ram_dout;
      end

      if (decide) begin
        gnt_q <= gnt_d;
        if (gnt_d == G_NONE) begin
          state_q <= S_IDLE;
        end else begin
          state_q <= S_ADDR;
          if (gnt_d == G_VID) begin
            vcnt_q     <= (vcnt_q == 2'd2) ? 2'd2 : vcnt_q + 2'd1;
            ram_addr_q <= vid_addr;
          end else begin
            vcnt_q <= '0;
          end
          if (gnt_d == G_DL) begin
            ram_addr_q <= buf_addr_q;
            ram_din_q  <= buf_data_q;
            ram_we_q   <= 1'b1;
          end
          if (gnt_d == G_CPU) begin
            ram_addr_q <= cpu_addr;
            ram_din_q  <= cpu_din;
            ram_we_q   <= cpu_we;
            cpu_we_q   <= cpu_we;
          end
        end
      end
    end
  end

  // Outputs are forced to their reset values during the reset cycle itself,
  // so an access interrupted by reset produces neither an ack nor a write.
  assign vid_ack    = vid_ack_q & ~reset;
  assign cpu_ack    = cpu_ack_q & ~reset;
  assign ram_we     = ram_we_q & ~reset;
  assign ioctl_wait = pend_q & ~reset;
  assign cpu_hold   = hold_q & ~reset;
  assign dl_overrun = ovr_q & ~reset;
  assign ram_addr   = reset ? '0 : ram_addr_q;
  assign vid_dout   = reset ? '0 : vid_dout_q;
  assign cpu_dout   = reset ? '0 : cpu_dout_q;
  assign ram_din    = ram_din_q;

endmodule

// File: tb/tb_lynx_ram_arbiter.sv
// Directed bench for lynx_ram_arbiter with a synchronous RAM model.
module tb_lynx_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_dout;
  logic        vid_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        cpu_hold;
  logic        dl_overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  lynx_ram_arbiter #(
    .DL_INDEX(8'd1),
    .DL_BASE (16'h4000)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .vid_req       (vid_req),
    .vid_addr      (vid_addr),
    .vid_dout      (vid_dout),
    .vid_ack       (vid_ack),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .cpu_dout      (cpu_dout),
    .cpu_ack       (cpu_ack),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_index   (ioctl_index),
    .ioctl_wait    (ioctl_wait),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .cpu_hold      (cpu_hold),
    .dl_overrun    (dl_overrun)
  );

  // RAM model with a bench-side preload port
  logic [7:0]  mem [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (pl_we) mem[pl_addr] <= pl_data;
    ram_dout <= mem[ram_addr];
  end

  // Ack monitor: grant order, overlap and CPU ack count
  logic log_en = 1'b0;
  int   ack_log[$];
  int   overlap = 0;
  int   cpu_ack_cnt = 0;

  always @(negedge clk_sys) begin
    if (log_en) begin
      if (vid_ack) ack_log.push_back(1);
      if (cpu_ack) ack_log.push_back(2);
      if (vid_ack && cpu_ack) overlap++;
    end
    if (cpu_ack) cpu_ack_cnt++;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    step();
    pl_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order [6] = '{1, 1, 2, 1, 1, 2};
    int c0;
    logic got;

    reset = 1'b1;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0;

    preload(16'h1234, 8'hA5);
    preload(16'h2000, 8'h11);
    preload(16'h4000, 8'hEE);
    preload(16'h4011, 8'h5A);
    preload(16'h0055, 8'h00);

    // Reset state
    check("rst_ram_we",     ram_we,     1'b0);
    check("rst_cpu_hold",   cpu_hold,   1'b0);
    check("rst_acks",       {vid_ack, cpu_ack}, 2'b00);
    check("rst_ioctl_wait", ioctl_wait, 1'b0);
    check("rst_overrun",    dl_overrun, 1'b0);
    check("rst_douts",      {cpu_dout, vid_dout}, 16'h0000);
    check("rst_ram_addr",   ram_addr,   16'h0000);
    reset = 1'b0;
    step();

    // CPU read of 0x1234 -> A5
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    step();
    check("cpu_rd_addr",     ram_addr, 16'h1234);
    check("cpu_rd_we",       ram_we,   1'b0);
    check("cpu_rd_ack_early", cpu_ack, 1'b0);
    step();
    check("cpu_rd_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    step();
    check("cpu_rd_ack_clr", cpu_ack,  1'b0);
    check("cpu_rd_dout",    cpu_dout, 8'hA5);

    // CPU write 0x77 -> 0x0055; cpu_dout must keep A5
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0055; cpu_din = 8'h77;
    step();
    check("cpu_wr_we",   ram_we,  1'b1);
    check("cpu_wr_addr", ram_addr, 16'h0055);
    check("cpu_wr_din",  ram_din, 8'h77);
    step();
    check("cpu_wr_ack",    cpu_ack, 1'b1);
    check("cpu_wr_we_data", ram_we, 1'b0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
    check("cpu_wr_dout_kept", cpu_dout, 8'hA5);
    check("cpu_wr_mem",       mem[16'h0055], 8'h77);

    // Fairness: video and CPU requesting continuously
    vid_req = 1'b1; vid_addr = 16'h2000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    log_en  = 1'b1;
    repeat (12) step();
    vid_req = 1'b0; cpu_req = 1'b0;
    step();
    step();
    log_en = 1'b0;
    check("grant_count", ack_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("grant_order_%0d", i), (i < ack_log.size()) ? ack_log[i] : 0, exp_order[i]);
    check("ack_overlap", overlap, 0);
    check("vid_dout", vid_dout, 8'h11);

    // Download with foreign index: ignored
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    step();
    step();
    check("idx2_hold", cpu_hold, 1'b0);
    ioctl_wr = 1'b1; ioctl_addr = 25'h0010; ioctl_dout = 8'h99;
    step();
    ioctl_wr = 1'b0;
    check("idx2_wait", ioctl_wait, 1'b0);
    step();
    check("idx2_we", ram_we, 1'b0);

    // Download index 1, out-of-range address discarded
    ioctl_index = 8'd1;
    step();
    check("dl_hold", cpu_hold, 1'b1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h10000; ioctl_dout = 8'h55;
    step();
    ioctl_wr = 1'b0;
    check("hi_addr_wait", ioctl_wait, 1'b0);
    step();
    check("hi_addr_we", ram_we, 1'b0);
    step();
    check("hi_addr_mem", mem[16'h4000], 8'hEE);

    // Byte 3C to 0x10 -> RAM 0x4010; second write while busy is dropped
    ioctl_wr = 1'b1; ioctl_addr = 25'h0010; ioctl_dout = 8'h3C;
    step();
    check("dl_wait_set",   ioctl_wait, 1'b1);
    check("dl_ovr_before", dl_overrun, 1'b0);
    ioctl_addr = 25'h0011; ioctl_dout = 8'hC3;
    step();
    ioctl_wr = 1'b0;
    check("dl_we",       ram_we,     1'b1);
    check("dl_addr",     ram_addr,   16'h4010);
    check("dl_din",      ram_din,    8'h3C);
    check("dl_overrun",  dl_overrun, 1'b1);
    check("dl_wait_hold", ioctl_wait, 1'b1);
    check("dl_hold_addr", cpu_hold,  1'b1);
    step();
    check("dl_wait_clr", ioctl_wait, 1'b0);
    check("dl_mem",      mem[16'h4010], 8'h3C);
    check("dl_hold_data", cpu_hold,  1'b1);
    step();
    check("dl_dropped_mem", mem[16'h4011], 8'h5A);

    // Download ends with a byte still buffered: it drains, hold follows pending
    ioctl_wr = 1'b1; ioctl_addr = 25'h0020; ioctl_dout = 8'h42;
    step();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    check("drain_wait", ioctl_wait, 1'b1);
    step();
    check("drain_we",   ram_we,   1'b1);
    check("drain_addr", ram_addr, 16'h4020);
    check("drain_hold_addr", cpu_hold, 1'b1);
    step();
    check("drain_hold_data", cpu_hold, 1'b1);
    check("drain_wait_clr",  ioctl_wait, 1'b0);
    step();
    check("drain_hold_clr", cpu_hold, 1'b0);
    check("drain_mem",      mem[16'h4020], 8'h42);
    check("ovr_sticky",     dl_overrun, 1'b1);

    // CPU blocked while held, served once hold drops
    ioctl_download = 1'b1;
    step();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    c0 = cpu_ack_cnt;
    repeat (4) step();
    check("cpu_blocked", cpu_ack_cnt - c0, 0);
    ioctl_download = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("cpu_after_hold", got, 1'b1);
    cpu_req = 1'b0;
    step();

    // Reset during DATA of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0066; cpu_din = 8'h88;
    step();
    check("rstmid_we_addr", ram_we, 1'b1);
    step();
    reset = 1'b1;
    #1;
    check("rstmid_ack", cpu_ack, 1'b0);
    step();
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    check("rstmid_acks",    {vid_ack, cpu_ack}, 2'b00);
    check("rstmid_we",      ram_we,     1'b0);
    check("rstmid_overrun", dl_overrun, 1'b0);
    check("rstmid_douts",   {cpu_dout, vid_dout}, 16'h0000);
    check("rstmid_addr",    ram_addr,   16'h0000);
    check("rstmid_hold_wait", {cpu_hold, ioctl_wait}, 2'b00);
    step();
    check("rstmid_idle_we", ram_we, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
